// File: rtl/zebra_stripe_analyzer.sv
// zebra_stripe_analyzer
// Downstream stage of the zebra-crossing white-pixel detector. Forwards the
// greyscale stream through a one-stage registered pass-through, measures
// white runs per row, counts rows holding enough wide stripes and issues one
// zebra decision per frame.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high; valid, once raised, holds its data until the transfer, and ready
// may depend combinationally on the downstream ready (x_ready = y_ready ||
// !y_valid).
module zebra_stripe_analyzer #(
    parameter int           IMG_WIDTH       = 320,
    parameter int           IMG_HEIGHT      = 240,
    parameter int           W               = 8,
    parameter logic [W-1:0] WHITE_THRESHOLD = 8'd180,
    parameter int           MIN_RUN         = 8,
    parameter int           MIN_STRIPES     = 3,
    parameter int           MIN_ROWS        = 20
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            x_valid,
    output logic                            x_ready,
    input  logic [W-1:0]                    x_data,
    output logic                            y_valid,
    input  logic                            y_ready,
    output logic [W-1:0]                    y_data,
    output logic [7:0]                      row_stripes,
    output logic [$clog2(IMG_HEIGHT+1)-1:0] stripe_rows,
    output logic                            zebra_detected,
    output logic                            detection_valid
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int RW = $clog2(MIN_RUN + 1);
    localparam int TW = $clog2(IMG_HEIGHT + 1);

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MIN_RUN);

    typedef enum logic {
        BLACK = 1'b0,
        WHITE = 1'b1
    } row_state_t;

    // Row FSM state; kept as a named signal so checkers can bind to it.
    row_state_t    row_state;

    logic [XW-1:0] x_pos;
    logic [YW-1:0] y_pos;
    logic [RW-1:0] run_len;
    logic [7:0]    cur_stripes;
    logic [TW-1:0] tally;

    logic          hs;
    logic          is_white;
    logic          row_end;
    logic          frame_end;
    logic [RW:0]   run_inc;
    logic [RW-1:0] run_next;
    logic          stripe_inc;
    logic [7:0]    final_count;
    logic          row_qualifies;
    logic [TW-1:0] final_tally;

    assign x_ready   = y_ready || !y_valid;
    assign hs        = x_valid && x_ready;
    assign is_white  = (x_data >= WHITE_THRESHOLD);
    assign row_end   = (x_pos == X_LAST);
    assign frame_end = row_end && (y_pos == Y_LAST);

    // Run length including the current pixel, and the row/frame counts that
    // result if the current pixel is accepted.
    always_comb begin
        run_inc = {1'b0, run_len} + (RW+1)'(1);
        if (row_state == BLACK) begin
            run_next = RW'(1);
        end else if (run_inc >= {1'b0, RUN_MAX}) begin
            run_next = RUN_MAX;
        end else begin
            run_next = run_inc[RW-1:0];
        end

        // A run closes on a black pixel, or is cut off by the right edge.
        if (is_white) begin
            stripe_inc = row_end && (run_next >= RUN_MAX);
        end else begin
            stripe_inc = (row_state == WHITE) && (run_len >= RUN_MAX);
        end

        if (stripe_inc && (cur_stripes != 8'hFF)) begin
            final_count = cur_stripes + 8'd1;
        end else begin
            final_count = cur_stripes;
        end

        row_qualifies = (32'(final_count) >= MIN_STRIPES);
        final_tally   = row_qualifies ? (tally + TW'(1)) : tally;
    end

    // One-stage registered pass-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
        end else if (hs) begin
            y_valid <= 1'b1;
            y_data  <= x_data;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

    // Raster position of the next accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos <= '0;
            y_pos <= '0;
        end else if (hs) begin
            if (row_end) begin
                x_pos <= '0;
                y_pos <= (y_pos == Y_LAST) ? '0 : (y_pos + YW'(1));
            end else begin
                x_pos <= x_pos + XW'(1);
            end
        end
    end

    // Row run FSM with per-row stripe count and per-frame row tally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_state       <= BLACK;
            run_len         <= '0;
            cur_stripes     <= '0;
            tally           <= '0;
            row_stripes     <= '0;
            stripe_rows     <= '0;
            zebra_detected  <= 1'b0;
            detection_valid <= 1'b0;
        end else begin
            detection_valid <= 1'b0;
            if (hs) begin
                if (row_end) begin
                    // Runs never span rows: the row closes here.
                    row_state   <= BLACK;
                    run_len     <= '0;
                    cur_stripes <= '0;
                    row_stripes <= final_count;
                    if (frame_end) begin
                        tally           <= '0;
                        stripe_rows     <= final_tally;
                        zebra_detected  <= (32'(final_tally) >= MIN_ROWS);
                        detection_valid <= 1'b1;
                    end else begin
                        tally <= final_tally;
                    end
                end else if (row_state == BLACK) begin
                    if (is_white) begin
                        run_len   <= run_next;
                        row_state <= WHITE;
                    end
                end else begin
                    if (is_white) begin
                        run_len <= run_next;
                    end else begin
                        cur_stripes <= final_count;
                        row_state   <= BLACK;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_zebra_stripe_analyzer.sv
// Bench for zebra_stripe_analyzer: hand-tabulated rows, hand-written frame
// sequences, backpressure, random rows, and a mid-frame reset. Rows are
// checked against a run-length model that scans a buffered copy of each row.
module tb_zebra_stripe_analyzer;

    localparam int         IMG_WIDTH   = 16;
    localparam int         IMG_HEIGHT  = 4;
    localparam int         W           = 8;
    localparam logic [7:0] THR         = 8'd180;
    localparam int         MIN_RUN     = 2;
    localparam int         MIN_STRIPES = 3;
    localparam int         MIN_ROWS    = 3;
    localparam int         TW          = $clog2(IMG_HEIGHT + 1);
    localparam int         RB          = IMG_WIDTH * 8;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          x_valid = 1'b0;
    logic          x_ready;
    logic [W-1:0]  x_data = '0;
    logic          y_valid;
    logic          y_ready = 1'b1;
    logic [W-1:0]  y_data;
    logic [7:0]    row_stripes;
    logic [TW-1:0] stripe_rows;
    logic          zebra_detected;
    logic          detection_valid;

    always #5 clk = ~clk;

    zebra_stripe_analyzer #(
        .IMG_WIDTH      (IMG_WIDTH),
        .IMG_HEIGHT     (IMG_HEIGHT),
        .W              (W),
        .WHITE_THRESHOLD(THR),
        .MIN_RUN        (MIN_RUN),
        .MIN_STRIPES    (MIN_STRIPES),
        .MIN_ROWS       (MIN_ROWS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .x_valid        (x_valid),
        .x_ready        (x_ready),
        .x_data         (x_data),
        .y_valid        (y_valid),
        .y_ready        (y_ready),
        .y_data         (y_data),
        .row_stripes    (row_stripes),
        .stripe_rows    (stripe_rows),
        .zebra_detected (zebra_detected),
        .detection_valid(detection_valid)
    );

    // ---------------- scoreboard state ----------------
    int           n_cmp = 0;
    int           n_fail = 0;
    int           det_pulses = 0;
    bit           bp_mode = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   row_buf[IMG_WIDTH];
    int           row_fill = 0;
    int           row_idx = 0;
    int           frame_tally = 0;

    typedef struct {
        logic [RB-1:0] pix;
        int            exp_stripes;
    } row_vec_t;

    row_vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Count runs of white pixels in the buffered row that reach MIN_RUN.
    function automatic int model_row_stripes();
        int n;
        int run;
        n = 0;
        run = 0;
        for (int i = 0; i < IMG_WIDTH; i++) begin
            if (row_buf[i] >= THR) begin
                run++;
            end else begin
                if (run >= MIN_RUN) n++;
                run = 0;
            end
        end
        if (run >= MIN_RUN) n++;
        return (n > 255) ? 255 : n;
    endfunction

    // Called just after the edge that accepted pixel d.
    task automatic model_pixel(input logic [7:0] d);
        int s;
        row_buf[row_fill] = d;
        row_fill++;
        if (row_fill == IMG_WIDTH) begin
            row_fill = 0;
            s = model_row_stripes();
            check($sformatf("row_stripes row%0d", row_idx), 32'(row_stripes), 32'(s));
            if (s >= MIN_STRIPES) frame_tally++;
            row_idx++;
            if (row_idx == IMG_HEIGHT) begin
                check("detection_valid at frame end", 32'(detection_valid), 32'd1);
                check("stripe_rows at frame end", 32'(stripe_rows), 32'(frame_tally));
                check("zebra_detected at frame end", 32'(zebra_detected),
                      32'(frame_tally >= MIN_ROWS));
                row_idx = 0;
                frame_tally = 0;
            end else begin
                check("detection_valid quiet mid-frame", 32'(detection_valid), 32'd0);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_pixel(input logic [7:0] d);
        int  guard;
        bit  done;
        guard = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            y_ready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (bp_mode && ($urandom_range(0, 2) == 0)) begin
                x_valid = 1'b0;
                x_data  = 8'($urandom);
            end else begin
                x_valid = 1'b1;
                x_data  = d;
            end
            #1;
            if (x_valid && x_ready) begin
                done = 1'b1;
                exp_q.push_back(d);
            end
            guard++;
            if (!done && guard > 200) begin
                check("x_ready timeout", 32'd0, 32'd1);
                x_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        model_pixel(d);
    endtask

    task automatic send_row(input logic [RB-1:0] p);
        for (int i = 0; i < IMG_WIDTH; i++) send_pixel(p[i*8 +: 8]);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            y_ready = 1'b1;
            x_valid = 1'b0;
            #3;
            guard++;
        end while (exp_q.size() != 0 && guard < 100);
        check("output queue drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " y_valid"}, 32'(y_valid), 32'd0);
        check({tag, " y_data"}, 32'(y_data), 32'd0);
        check({tag, " row_stripes"}, 32'(row_stripes), 32'd0);
        check({tag, " stripe_rows"}, 32'(stripe_rows), 32'd0);
        check({tag, " zebra_detected"}, 32'(zebra_detected), 32'd0);
        check({tag, " detection_valid"}, 32'(detection_valid), 32'd0);
        check({tag, " x_ready"}, 32'(x_ready), 32'd1);
    endtask

    function automatic logic [RB-1:0] row_from_str(input string s);
        logic [RB-1:0] p;
        p = '0;
        for (int i = 0; i < IMG_WIDTH; i++) p[i*8 +: 8] = (s[i] == "W") ? 8'd200 : 8'd0;
        return p;
    endfunction

    function automatic logic [RB-1:0] edge_row(input int tail_whites);
        logic [RB-1:0] p;
        p = '0;
        p[0*8 +: 8] = 8'd180;
        p[1*8 +: 8] = 8'd180;
        for (int i = 2; i < IMG_WIDTH; i++)
            p[i*8 +: 8] = (i >= IMG_WIDTH - tail_whites) ? 8'd255 : 8'd179;
        return p;
    endfunction

    function automatic logic [RB-1:0] random_row();
        logic [RB-1:0] p;
        for (int i = 0; i < IMG_WIDTH; i++) begin
            case ($urandom_range(0, 9))
                0:       p[i*8 +: 8] = 8'd180;
                1:       p[i*8 +: 8] = 8'd179;
                2, 3, 4, 5:
                         p[i*8 +: 8] = 8'($urandom_range(180, 255));
                default: p[i*8 +: 8] = 8'($urandom_range(0, 179));
            endcase
        end
        return p;
    endfunction

    // ---------------- output monitor / scoreboard ----------------
    // Inputs change on the falling edge; outputs are sampled shortly after.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (y_valid && !y_ready) check("x_ready low while stalled", 32'(x_ready), 32'd0);
            if (y_valid && y_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected output pixel", 32'(y_data), 32'hFFFF_FFFF);
                end else begin
                    check("y_data", 32'(y_data), 32'(exp_q.pop_front()));
                end
            end
            if (detection_valid) det_pulses++;
        end
    end

    // ---------------- stimulus ----------------
    logic [RB-1:0] stripes;
    logic [RB-1:0] black;
    int            pulses_before;

    initial begin
        stripes = row_from_str("WW0WW0WW00000000");
        black   = '0;

        vecs[0] = '{stripes, 3};
        vecs[1] = '{edge_row(1), 1};
        vecs[2] = '{edge_row(2), 2};
        vecs[3] = '{black, 0};
        vecs[4] = '{row_from_str("WWWWWWWWWWWWWWWW"), 1};
        vecs[5] = '{row_from_str("W0W0W0W0W0W0W0W0"), 0};
        vecs[6] = '{row_from_str("WWW0WWW0WW0WW000"), 4};
        vecs[7] = '{row_from_str("0WW0WW0WW0WW0W0W"), 4};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Stripes frame, no backpressure
        pulses_before = det_pulses;
        for (int r = 0; r < IMG_HEIGHT; r++) begin
            send_row(stripes);
            check("stripes frame row_stripes", 32'(row_stripes), 32'd3);
        end
        check("stripes frame stripe_rows", 32'(stripe_rows), 32'd4);
        check("stripes frame zebra_detected", 32'(zebra_detected), 32'd1);
        drain();
        check("stripes frame pulse count", 32'(det_pulses - pulses_before), 32'd1);

        // Tabulated rows (two frames)
        for (int v = 0; v < 8; v++) begin
            send_row(vecs[v].pix);
            check($sformatf("table row %0d row_stripes", v), 32'(row_stripes),
                  32'(vecs[v].exp_stripes));
        end
        check("table frame2 stripe_rows", 32'(stripe_rows), 32'd2);
        check("table frame2 zebra_detected", 32'(zebra_detected), 32'd0);
        drain();

        // Non-qualifying frame followed by a full-stripe frame
        send_row(stripes);
        send_row(stripes);
        send_row(black);
        send_row(black);
        check("nonqual stripe_rows", 32'(stripe_rows), 32'd2);
        check("nonqual zebra_detected", 32'(zebra_detected), 32'd0);
        for (int r = 0; r < IMG_HEIGHT; r++) send_row(stripes);
        check("requal stripe_rows", 32'(stripe_rows), 32'd4);
        check("requal zebra_detected", 32'(zebra_detected), 32'd1);
        drain();

        // Backpressure over the stripes frame
        bp_mode = 1'b1;
        pulses_before = det_pulses;
        for (int r = 0; r < IMG_HEIGHT; r++) send_row(stripes);
        check("bp stripe_rows", 32'(stripe_rows), 32'd4);
        check("bp zebra_detected", 32'(zebra_detected), 32'd1);
        drain();
        check("bp pulse count", 32'(det_pulses - pulses_before), 32'd1);

        // Random rows under backpressure
        for (int r = 0; r < 3 * IMG_HEIGHT; r++) send_row(random_row());
        drain();
        bp_mode = 1'b0;

        // Reset at row 2, column 5
        send_row(stripes);
        send_row(stripes);
        for (int c = 0; c < 5; c++) send_pixel(8'd200);
        @(negedge clk);
        rst_n   = 1'b0;
        x_valid = 1'b0;
        exp_q.delete();
        row_fill = 0;
        row_idx = 0;
        frame_tally = 0;
        #1;
        check_outputs_zero("mid-frame reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses_before = det_pulses;
        for (int r = 0; r < IMG_HEIGHT; r++) send_row(stripes);
        check("post-reset stripe_rows", 32'(stripe_rows), 32'd4);
        check("post-reset zebra_detected", 32'(zebra_detected), 32'd1);
        drain();
        check("post-reset pulse count", 32'(det_pulses - pulses_before), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Time limit
    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
